// File: rtl/stroke_ratio_meter_pkg.sv
// ratio_defs: phase encodings and numerator-width helper shared by the stroke ratio meter.
package ratio_defs;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, RECOVERY = 2'd2} phase_t;
  function automatic int calc_num_w(input int cnt_w, input int scale);
    return cnt_w + $clog2(scale + 1);
  endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle, done pulse then free on the next cycle.
module seq_divider #(
  parameter int NUM_W = 36,
  parameter int CNT_W = 32
) (
  input  logic             count_clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);
  localparam int STEP_W = $clog2(NUM_W + 2);
  logic [NUM_W-1:0]  r_q;
  logic [CNT_W-1:0]  r_rem, r_div, w_diff;
  logic [STEP_W-1:0] r_step;
  logic              r_busy, r_done, w_ge;
  logic [CNT_W:0]    w_sh;
  always_comb begin
    w_sh   = {r_rem, r_q[NUM_W-1]};
    w_ge   = w_sh[CNT_W] || (w_sh[CNT_W-1:0] >= r_div);
    w_diff = w_sh[CNT_W-1:0] - r_div;
  end
  always_ff @(negedge count_clock) begin
    if (reset) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_step <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (start && !r_busy) begin
      r_q    <= dividend;
      r_rem  <= '0;
      r_div  <= divisor;
      r_step <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_done) begin
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else if (r_busy) begin
      if (r_step == STEP_W'(NUM_W)) r_done <= 1'b1;
      else begin
        r_rem  <= w_ge ? w_diff : w_sh[CNT_W-1:0];
        r_q    <= {r_q[NUM_W-2:0], w_ge};
        r_step <= r_step + 1'b1;
      end
    end
  end
  assign busy     = r_busy;
  assign done     = r_done;
  assign quotient = (r_div == '0) ? '0 : r_q;
endmodule

// File: rtl/stroke_ratio_meter.sv
// stroke_ratio_meter: times drive/recovery phases per stroke, divides in the background
// and keeps a moving average of the recovery:drive ratio.
module stroke_ratio_meter
  import ratio_defs::*;
#(
  parameter int CNT_W     = 32,
  parameter int SCALE     = 10,
  parameter int RATIO_W   = 8,
  parameter int RATIO_MAX = 99,
  parameter int AVG_LOG2  = 2,
  parameter int TIMEOUT   = 2**24
) (
  input  logic               count_clock,
  input  logic               reset,
  input  logic               start_drive,
  input  logic               start_recovery,
  output logic [RATIO_W-1:0] ratio,
  output logic               ratio_valid,
  output logic [RATIO_W-1:0] ratio_avg,
  output logic               avg_valid,
  output logic               avg_full,
  output logic [1:0]         phase,
  output logic               idle,
  output logic               overrun
);
  localparam int NUM_W = calc_num_w(CNT_W, SCALE);
  localparam int N     = 2**AVG_LOG2;
  localparam int SUM_W = RATIO_W + AVG_LOG2;
  localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT);
  localparam logic [NUM_W-1:0] MAX_Q = NUM_W'(RATIO_MAX);
  phase_t             r_phase, w_next;
  logic               r_sd, r_sr, w_fd, w_rr, w_to, w_bnd, w_clr;
  logic [CNT_W-1:0]   r_drive, r_rec;
  logic               w_busy, w_done;
  logic [NUM_W-1:0]   w_num, w_quo;
  logic [RATIO_W-1:0] w_sat, r_ratio, r_avg;
  logic               r_ratio_valid, r_avg_valid, r_ovr;
  logic [RATIO_W-1:0] r_hist [N];
  logic [AVG_LOG2-1:0] r_ptr;
  logic [AVG_LOG2:0]  r_fill;
  logic [SUM_W-1:0]   r_sum, w_sum_new;
  always_comb begin
    w_fd   = r_sd && !start_drive;
    w_rr   = !r_sr && start_recovery && !w_fd;
    w_to   = (r_phase == DRIVE && r_drive >= TO_V) || (r_phase == RECOVERY && r_rec >= TO_V);
    w_bnd  = w_fd && r_phase == RECOVERY;
    w_next = w_fd ? DRIVE : w_to ? IDLE : (w_rr && r_phase == DRIVE) ? RECOVERY : r_phase;
    w_clr  = w_next == IDLE && r_phase != IDLE;
    w_num  = NUM_W'(r_rec) * NUM_W'(SCALE);
    w_sat  = (w_quo > MAX_Q) ? RATIO_W'(RATIO_MAX) : w_quo[RATIO_W-1:0];
    w_sum_new = r_sum + SUM_W'(r_ratio) - SUM_W'(r_hist[r_ptr]);
  end
  always_ff @(negedge count_clock) begin
    r_phase <= reset ? IDLE : w_next;
    r_sd    <= reset ? 1'b0 : start_drive;
    r_sr    <= reset ? 1'b0 : start_recovery;
    r_ovr   <= reset ? 1'b0 : (r_ovr || (w_bnd && w_busy));
  end
  always_ff @(negedge count_clock) begin
    if (reset || w_clr) begin
      r_drive <= '0;
      r_rec   <= '0;
    end else if (w_fd) begin
      r_drive <= CNT_W'(1);
      r_rec   <= '0;
    end else if (w_next == RECOVERY && r_phase == DRIVE) r_rec <= CNT_W'(1);
    else if (r_phase == DRIVE) r_drive <= (&r_drive) ? r_drive : r_drive + 1'b1;
    else if (r_phase == RECOVERY) r_rec <= (&r_rec) ? r_rec : r_rec + 1'b1;
  end
  seq_divider #(.NUM_W(NUM_W), .CNT_W(CNT_W)) u_div (
    .count_clock(count_clock),
    .reset      (reset),
    .start      (w_bnd),
    .dividend   (w_num),
    .divisor    (r_drive),
    .busy       (w_busy),
    .done       (w_done),
    .quotient   (w_quo)
  );
  // An in-flight result still lands after idle; a clear in the same cycle wins.
  always_ff @(negedge count_clock) begin
    if (reset) begin
      r_ratio       <= '0;
      r_ratio_valid <= 1'b0;
      r_avg         <= '0;
      r_avg_valid   <= 1'b0;
      r_sum         <= '0;
      r_ptr         <= '0;
      r_fill        <= '0;
      for (int i = 0; i < N; i++) r_hist[i] <= '0;
    end else begin
      r_ratio_valid <= w_done;
      if (w_done) r_ratio <= w_sat;
      r_avg_valid <= r_ratio_valid && !w_clr;
      if (w_clr) begin
        r_sum  <= '0;
        r_ptr  <= '0;
        r_fill <= '0;
        for (int i = 0; i < N; i++) r_hist[i] <= '0;
      end else if (r_ratio_valid) begin
        r_hist[r_ptr] <= r_ratio;
        r_sum         <= w_sum_new;
        r_ptr         <= r_ptr + 1'b1;
        r_avg         <= w_sum_new[SUM_W-1:AVG_LOG2];
        r_fill        <= r_fill[AVG_LOG2] ? r_fill : r_fill + 1'b1;
      end
    end
  end
  assign ratio       = r_ratio;
  assign ratio_valid = r_ratio_valid;
  assign ratio_avg   = r_avg;
  assign avg_valid   = r_avg_valid;
  assign avg_full    = r_fill[AVG_LOG2];
  assign phase       = r_phase;
  assign idle        = r_phase == IDLE;
  assign overrun     = r_ovr;
endmodule

// File: tb/tb_stroke_ratio_meter.sv
// tb_stroke_ratio_meter: directed strokes with hand-computed ratios, averages and latencies.
module tb_stroke_ratio_meter;
  localparam int LAT = 38;
  logic       count_clock, reset, start_drive, start_recovery;
  logic [7:0] ratio, ratio_avg;
  logic       ratio_valid, avg_valid, avg_full, idle, overrun;
  logic [1:0] phase;
  int         errors = 0, checks = 0, rv_count = 0, snap;
  stroke_ratio_meter #(.TIMEOUT(100)) dut (
    .count_clock   (count_clock),
    .reset         (reset),
    .start_drive   (start_drive),
    .start_recovery(start_recovery),
    .ratio         (ratio),
    .ratio_valid   (ratio_valid),
    .ratio_avg     (ratio_avg),
    .avg_valid     (avg_valid),
    .avg_full      (avg_full),
    .phase         (phase),
    .idle          (idle),
    .overrun       (overrun)
  );
  initial begin
    count_clock = 0;
    forever #5 count_clock = ~count_clock;
  end
  always @(negedge count_clock) if (ratio_valid) rv_count++;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge count_clock);
  endtask
  task automatic ev(input logic fd, input logic rr);
    start_drive = !fd;
    start_recovery = rr;
    @(posedge count_clock);
    start_drive = 1'b1;
    start_recovery = 1'b0;
  endtask
  task automatic run_stroke(input int d, input int r, input int q, input int avg, input logic full, input string tag);
    ev(1, 0);
    cyc(d - 1);
    ev(0, 1);
    chk({tag, "_phase_rec"}, phase, 2);
    cyc(r - 1);
    ev(1, 0);
    cyc(LAT - 1);
    chk({tag, "_rv_early"}, ratio_valid, 0);
    cyc(1);
    chk({tag, "_rv"}, ratio_valid, 1);
    chk({tag, "_ratio"}, ratio, q);
    cyc(1);
    chk({tag, "_avg_valid"}, avg_valid, 1);
    chk({tag, "_avg"}, ratio_avg, avg);
    chk({tag, "_full"}, avg_full, full);
  endtask
  initial begin
    reset = 1; start_drive = 1; start_recovery = 0;
    cyc(3);
    reset = 0;
    cyc(2);
    chk("rst_ratio", ratio, 0);
    chk("rst_avg", ratio_avg, 0);
    chk("rst_rv", ratio_valid, 0);
    chk("rst_full", avg_full, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_phase", phase, 0);
    chk("rst_idle", idle, 1);
    run_stroke(20, 40, 20, 5, 0, "s1");
    run_stroke(20, 40, 20, 10, 0, "s2");
    run_stroke(20, 60, 30, 17, 0, "s3");
    run_stroke(20, 60, 30, 25, 1, "s4");
    run_stroke(10, 40, 40, 30, 1, "s5");
    run_stroke(4, 50, 99, 49, 1, "sat");
    run_stroke(30, 40, 13, 45, 1, "trunc");
    // restart: fd+rr together in DRIVE reloads the drive count
    snap = rv_count;
    ev(1, 0);
    cyc(14);
    ev(1, 1);
    chk("restart_phase", phase, 1);
    cyc(9);
    ev(0, 1);
    cyc(19);
    ev(1, 0);
    cyc(LAT);
    chk("restart_ratio", ratio, 20);
    cyc(1);
    chk("restart_rv_count", rv_count, snap + 1);
    chk("restart_avg", ratio_avg, 43);
    ev(1, 0);
    cyc(4);
    ev(0, 1);
    cyc(97);
    chk("to_before", phase, 2);
    cyc(5);
    chk("to_phase", phase, 0);
    chk("to_idle", idle, 1);
    chk("to_full", avg_full, 0);
    chk("to_ratio_hold", ratio, 20);
    chk("to_avg_hold", ratio_avg, 43);
    snap = rv_count;
    ev(1, 0);
    chk("idle_fd_phase", phase, 1);
    cyc(45);
    chk("idle_fd_no_result", rv_count, snap);
    run_stroke(20, 40, 20, 5, 0, "post_idle");
    ev(1, 0);
    cyc(19);
    ev(0, 1);
    cyc(39);
    ev(1, 0);
    cyc(19);
    ev(0, 1);
    cyc(LAT - 20);
    chk("b2b_x_rv", ratio_valid, 1);
    chk("b2b_x_ratio", ratio, 20);
    ev(1, 0);
    chk("b2b_no_ovr", overrun, 0);
    cyc(LAT - 1);
    chk("b2b_y_early", ratio_valid, 0);
    cyc(1);
    chk("b2b_y_rv", ratio_valid, 1);
    chk("b2b_y_ratio", ratio, 9);
    ev(1, 0);
    snap = rv_count;
    cyc(9);
    ev(0, 1);
    cyc(9);
    ev(1, 0);
    chk("ovr_before", overrun, 0);
    cyc(1);
    ev(0, 1);
    cyc(2);
    ev(1, 0);
    chk("ovr_set", overrun, 1);
    cyc(LAT - 6);
    chk("ovr_a_early", ratio_valid, 0);
    cyc(1);
    chk("ovr_a_rv", ratio_valid, 1);
    chk("ovr_a_ratio", ratio, 10);
    cyc(60);
    chk("ovr_one_result", rv_count, snap + 1);
    chk("ovr_sticky", overrun, 1);
    ev(1, 0);
    cyc(9);
    ev(0, 1);
    cyc(9);
    ev(1, 0);
    cyc(10);
    reset = 1;
    cyc(2);
    reset = 0;
    snap = rv_count;
    chk("mid_rst_ratio", ratio, 0);
    chk("mid_rst_avg", ratio_avg, 0);
    chk("mid_rst_rv", ratio_valid, 0);
    chk("mid_rst_av", avg_valid, 0);
    chk("mid_rst_full", avg_full, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_phase", phase, 0);
    chk("mid_rst_idle", idle, 1);
    cyc(60);
    chk("mid_rst_no_late_rv", rv_count, snap);
    chk("mid_rst_ratio_late", ratio, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stroke_ratio_meter.md
# stroke_ratio_meter

Parametrised successor to the erg's single-channel ratio counter. It times the drive and recovery phases of each stroke in `count_clock` cycles and computes the recovery:drive ratio as `SCALE * recovery / drive`. A sequential divider computes the ratio in the background while the next stroke is already being timed. The block also keeps a moving average over the last `2**AVG_LOG2` strokes, detects idle via a timeout, and feeds the display/telemetry path.

## Interface
- `CNT_W`, 32: width of the drive and recovery phase counters; both saturate at all-ones.
- `SCALE`, 10: fixed-point multiplier applied to the recovery count.
- `RATIO_W`, 8: width of the ratio outputs.
- `RATIO_MAX`, 99: saturation value for the ratio; must be ≤ `2**RATIO_W-1`.
- `AVG_LOG2`, 2: the moving average covers `2**AVG_LOG2` strokes.
- `TIMEOUT`, `2**24`: cycles without a stroke boundary before the block goes idle.
- `count_clock` in 1: the single clock; all logic is on its negative edge.
- `reset` in 1: synchronous, active-high.
- `start_drive` in 1: drive sensor level; its falling edge marks the stroke boundary.
- `start_recovery` in 1: recovery sensor level; its rising edge marks the start of recovery.
- `ratio` out `RATIO_W`: latest ratio; held until the next result.
- `ratio_valid` out 1: one-cycle pulse when `ratio` updates.
- `ratio_avg` out `RATIO_W`: moving-average ratio.
- `avg_valid` out 1: one-cycle pulse when `ratio_avg` updates.
- `avg_full` out 1: high once `2**AVG_LOG2` results have been collected since reset or idle.
- `phase` out 2: current state; IDLE=0, DRIVE=1, RECOVERY=2.
- `idle` out 1: high while `phase` is IDLE.
- `overrun` out 1: sticky flag; a stroke result was dropped because the divider was busy. Cleared only by reset.

## Operation
- Edge detection uses registered copies of both inputs; these reset to 0.
  - `fd` = falling edge of `start_drive`.
  - `rr` = rising edge of `start_recovery`.
- If `fd` and `rr` occur in the same cycle, `fd` wins and `rr` is ignored.
- FSM transitions:
  - IDLE, on `fd` → DRIVE. No result is produced.
  - DRIVE, on `fd` → DRIVE. The stroke restarts and no result is produced.
  - DRIVE, on `rr` → RECOVERY.
  - RECOVERY, on `fd` → DRIVE. This is a stroke boundary and produces a result.
  - `rr` in IDLE or RECOVERY is ignored.
  - Any state except IDLE: when the current phase counter reaches `TIMEOUT` → IDLE.
- Counters:
  - Entering DRIVE loads `drive_cnt`=1 and clears `rec_cnt`.
  - Entering RECOVERY loads `rec_cnt`=1.
  - Each later cycle in a phase increments that phase's counter, saturating at `2**CNT_W-1`.
- Stroke boundary:
  - The numerator `rec_cnt*SCALE` (width `NUM_W = CNT_W + $clog2(SCALE+1)`) and the divisor `drive_cnt` are captured and the divider starts.
  - If the divider is busy, the capture is dropped and `overrun` is set.
- Result rules:
  - If the divisor is 0, the result is 0.
  - The quotient is truncated.
  - A quotient above `RATIO_MAX` saturates to `RATIO_MAX`.
- Moving average:
  - History is a circular buffer of `2**AVG_LOG2` entries plus a running sum of width `RATIO_W+AVG_LOG2`.
  - On each result: `sum += new - oldest`, the new value overwrites the oldest, and `ratio_avg = sum >> AVG_LOG2`.
  - The buffer starts zero-filled, so the average ramps up until `avg_full`.
- Timeout to IDLE:
  - Clears the counters, history, sum and `avg_full`.
  - A divide already in flight still completes and updates `ratio` and the history.
  - `ratio` and `ratio_avg` hold their last values.

## Timing
- Reset values:
  - `ratio`, `ratio_avg`: 0.
  - `ratio_valid`, `avg_valid`, `avg_full`, `overrun`: 0.
  - `phase`: IDLE, `idle`: 1.
  - History, sum and divider: cleared.
- Divider latency:
  - Restoring divider, one quotient bit per cycle.
  - `ratio_valid` pulses exactly `NUM_W+2` cycles after the edge that samples the boundary (boundary = cycle 0).
  - `avg_valid` pulses one cycle after `ratio_valid`.
- The divider is free again on the cycle after `ratio_valid`. A boundary sampled in that cycle is accepted.
- `phase` and `idle` are registered; they change the cycle after the edge is sampled.
- Reset asserted mid-divide aborts the divide. No `ratio_valid` is produced afterwards.

## Structure
- Shared header `ratio_defs`:
  - Phase encodings IDLE/DRIVE/RECOVERY.
  - `NUM_W` derivation helper.
- Sub-module `seq_divider` (parametrised by `NUM_W` and `CNT_W`):
  - Ports: `start`, `dividend`, `divisor` in; `busy`, `done`, `quotient` out.
  - Same clock and reset as the parent.
- Top level holds the FSM, counters, saturation logic and the moving-average buffer.

## Test plan
- **Basic ratio:** `fd`, drive 20 cycles, `rr`, recovery 40 cycles, `fd` → `ratio`=20. `ratio_valid` pulses `NUM_W+2` cycles after the second `fd`.
- **Saturation:** drive 4, recovery 50 (500/4=125) → `ratio`=99.
- **Averaging:** four strokes with ratios 20, 20, 30, 30 → the fourth `ratio_avg`=25, `avg_full`=1. A fifth stroke with ratio 40 → `ratio_avg`=30.
- **Timeout:** with `TIMEOUT`=100, hold in RECOVERY for 100 cycles → `phase`=IDLE, `idle`=1, `avg_full`=0. The next `fd` → DRIVE with no result.
- **Simultaneous edges and drive restart:**
  - `fd` and `rr` in the same cycle while in DRIVE → stays in DRIVE and `drive_cnt` reloads to 1.
  - A second `fd` in DRIVE produces no `ratio_valid`.
- **Overrun and reset:**
  - Two boundaries 5 cycles apart → second result dropped, `overrun`=1.
  - `reset` asserted mid-divide → all outputs return to reset values and no late `ratio_valid` appears.
